// File: rtl/tlb_array.sv
// tlb_array: fully associative MIPS32 joint TLB with two search ports, one write
// port (tlbwi) and one read port (tlbr).
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   s{0,1}_vpn2/odd_page/asid        search key (VA[31:13], VA[12], ASID)
//   s{0,1}_found/index/pfn/c/d/v     search result, lowest matching entry
//   we, w_index, w_*                 entry write (takes effect at posedge)
//   r_index, r_*                     stored contents of entry[r_index]
//
// Search and read outputs are combinational from the stored entries. A write is
// visible from the cycle after its posedge; there is no write-to-search bypass.
module tlb_array #(
    parameter int unsigned TLBNUM      = 16,
    parameter int unsigned TLBNUM_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    // search port 0 (instruction/data translation)
    input  logic [18:0]            s0_vpn2,
    input  logic                   s0_odd_page,
    input  logic [7:0]             s0_asid,
    output logic                   s0_found,
    output logic [TLBNUM_LOG2-1:0] s0_index,
    output logic [19:0]            s0_pfn,
    output logic [2:0]             s0_c,
    output logic                   s0_d,
    output logic                   s0_v,
    // search port 1 (tlbp)
    input  logic [18:0]            s1_vpn2,
    input  logic                   s1_odd_page,
    input  logic [7:0]             s1_asid,
    output logic                   s1_found,
    output logic [TLBNUM_LOG2-1:0] s1_index,
    output logic [19:0]            s1_pfn,
    output logic [2:0]             s1_c,
    output logic                   s1_d,
    output logic                   s1_v,
    // write port (tlbwi)
    input  logic                   we,
    input  logic [TLBNUM_LOG2-1:0] w_index,
    input  logic [18:0]            w_vpn2,
    input  logic [7:0]             w_asid,
    input  logic                   w_g,
    input  logic [19:0]            w_pfn0,
    input  logic [2:0]             w_c0,
    input  logic                   w_d0,
    input  logic                   w_v0,
    input  logic [19:0]            w_pfn1,
    input  logic [2:0]             w_c1,
    input  logic                   w_d1,
    input  logic                   w_v1,
    // read port (tlbr)
    input  logic [TLBNUM_LOG2-1:0] r_index,
    output logic [18:0]            r_vpn2,
    output logic [7:0]             r_asid,
    output logic                   r_g,
    output logic [19:0]            r_pfn0,
    output logic [2:0]             r_c0,
    output logic                   r_d0,
    output logic                   r_v0,
    output logic [19:0]            r_pfn1,
    output logic [2:0]             r_c1,
    output logic                   r_d1,
    output logic                   r_v1
);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic                   found;
        logic [TLBNUM_LOG2-1:0] index;
        logic [19:0]            pfn;
        logic [2:0]             c;
        logic                   d;
        logic                   v;
    } search_t;

    tlb_entry_t          entry_q [TLBNUM];
    logic [TLBNUM-1:0]   e_q;

    // Entry storage. Out-of-range indices only exist for non-power-of-2 TLBNUM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_q <= '0;
            for (int i = 0; i < int'(TLBNUM); i++) begin
                entry_q[i] <= '0;
            end
        end else if (we && (32'(w_index) < TLBNUM)) begin
            e_q[w_index]     <= 1'b1;
            entry_q[w_index] <= '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                                  pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                                  pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
        end
    end

    // Both search ports share one loop body; index 0/1 selects the port.
    logic [18:0] s_vpn2 [2];
    logic [7:0]  s_asid [2];
    logic        s_odd  [2];
    search_t     s_res  [2];

    assign s_vpn2[0] = s0_vpn2;
    assign s_vpn2[1] = s1_vpn2;
    assign s_asid[0] = s0_asid;
    assign s_asid[1] = s1_asid;
    assign s_odd[0]  = s0_odd_page;
    assign s_odd[1]  = s1_odd_page;

    // Scanning from the top down lets the lowest matching index win.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            s_res[k] = '0;
            for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
                if (e_q[i] && (entry_q[i].vpn2 == s_vpn2[k]) &&
                    (entry_q[i].g || (entry_q[i].asid == s_asid[k]))) begin
                    s_res[k].found = 1'b1;
                    s_res[k].index = TLBNUM_LOG2'(i);
                    if (s_odd[k]) begin
                        s_res[k].pfn = entry_q[i].pfn1;
                        s_res[k].c   = entry_q[i].c1;
                        s_res[k].d   = entry_q[i].d1;
                        s_res[k].v   = entry_q[i].v1;
                    end else begin
                        s_res[k].pfn = entry_q[i].pfn0;
                        s_res[k].c   = entry_q[i].c0;
                        s_res[k].d   = entry_q[i].d0;
                        s_res[k].v   = entry_q[i].v0;
                    end
                end
            end
        end
    end

    assign s0_found = s_res[0].found;
    assign s0_index = s_res[0].index;
    assign s0_pfn   = s_res[0].pfn;
    assign s0_c     = s_res[0].c;
    assign s0_d     = s_res[0].d;
    assign s0_v     = s_res[0].v;
    assign s1_found = s_res[1].found;
    assign s1_index = s_res[1].index;
    assign s1_pfn   = s_res[1].pfn;
    assign s1_c     = s_res[1].c;
    assign s1_d     = s_res[1].d;
    assign s1_v     = s_res[1].v;

    tlb_entry_t r_entry;

    always_comb begin
        r_entry = '0;
        if (32'(r_index) < TLBNUM) begin
            r_entry = entry_q[r_index];
        end
    end

    assign r_vpn2 = r_entry.vpn2;
    assign r_asid = r_entry.asid;
    assign r_g    = r_entry.g;
    assign r_pfn0 = r_entry.pfn0;
    assign r_c0   = r_entry.c0;
    assign r_d0   = r_entry.d0;
    assign r_v0   = r_entry.v0;
    assign r_pfn1 = r_entry.pfn1;
    assign r_c1   = r_entry.c1;
    assign r_d1   = r_entry.d1;
    assign r_v1   = r_entry.v1;

endmodule

// File: tb/tb_tlb_array.sv
// Self-checking bench for tlb_array: directed scenarios plus a randomized run
// against an array-based reference model of the TLB contents.
module tb_tlb_array;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [18:0] s0_vpn2 = '0, s1_vpn2 = '0;
    logic        s0_odd_page = 1'b0, s1_odd_page = 1'b0;
    logic [7:0]  s0_asid = '0, s1_asid = '0;
    logic        s0_found, s1_found;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic        s0_d, s1_d, s0_v, s1_v;
    logic        we = 1'b0;
    logic [3:0]  w_index = '0;
    logic [18:0] w_vpn2 = '0;
    logic [7:0]  w_asid = '0;
    logic        w_g = 1'b0;
    logic [19:0] w_pfn0 = '0, w_pfn1 = '0;
    logic [2:0]  w_c0 = '0, w_c1 = '0;
    logic        w_d0 = 1'b0, w_v0 = 1'b0, w_d1 = 1'b0, w_v1 = 1'b0;
    logic [3:0]  r_index = '0;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic        r_d0, r_v0, r_d1, r_v1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tlb_array #(.TLBNUM(16), .TLBNUM_LOG2(4)) dut (
        .clk(clk), .resetn(resetn),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
    );

    // Reference model: plain arrays of what software has written.
    bit          m_e    [N];
    logic [18:0] m_vpn2 [N];
    logic [7:0]  m_asid [N];
    logic        m_g    [N];
    logic [19:0] m_pfn  [N][2];
    logic [2:0]  m_c    [N][2];
    logic        m_d    [N][2];
    logic        m_v    [N][2];

    function automatic logic [29:0] model_search(logic [18:0] vpn2, logic [7:0] asid,
                                                 logic odd);
        for (int i = 0; i < N; i++) begin
            if (m_e[i] && m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == asid))
                return {1'b1, 4'(i), m_pfn[i][odd], m_c[i][odd], m_d[i][odd], m_v[i][odd]};
        end
        return '0;
    endfunction

    function automatic logic [77:0] model_read(logic [3:0] idx);
        return {m_vpn2[idx], m_asid[idx], m_g[idx],
                m_pfn[idx][0], m_c[idx][0], m_d[idx][0], m_v[idx][0],
                m_pfn[idx][1], m_c[idx][1], m_d[idx][1], m_v[idx][1]};
    endfunction

    function automatic logic [29:0] dut_s0();
        return {s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v};
    endfunction

    function automatic logic [29:0] dut_s1();
        return {s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v};
    endfunction

    function automatic logic [77:0] dut_r();
        return {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_e[i] = 0; m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_pfn[i][p] = '0; m_c[i][p] = '0; m_d[i][p] = 1'b0; m_v[i][p] = 1'b0;
            end
        end
    endtask

    // Record the write currently presented on the w_* inputs.
    task automatic model_commit();
        m_e[w_index] = 1; m_vpn2[w_index] = w_vpn2; m_asid[w_index] = w_asid;
        m_g[w_index] = w_g;
        m_pfn[w_index][0] = w_pfn0; m_c[w_index][0] = w_c0;
        m_d[w_index][0] = w_d0; m_v[w_index][0] = w_v0;
        m_pfn[w_index][1] = w_pfn1; m_c[w_index][1] = w_c1;
        m_d[w_index][1] = w_d1; m_v[w_index][1] = w_v1;
    endtask

    task automatic drive_write(input logic [3:0] idx, input logic [18:0] vpn2,
                               input logic [7:0] asid, input logic g,
                               input logic [19:0] p0, input logic [2:0] c0,
                               input logic d0, input logic v0,
                               input logic [19:0] p1, input logic [2:0] c1,
                               input logic d1, input logic v1);
        we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = p0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = p1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    endtask

    task automatic do_write(input logic [3:0] idx, input logic [18:0] vpn2,
                            input logic [7:0] asid, input logic g,
                            input logic [19:0] p0, input logic [2:0] c0,
                            input logic d0, input logic v0,
                            input logic [19:0] p1, input logic [2:0] c1,
                            input logic d1, input logic v1);
        @(negedge clk);
        drive_write(idx, vpn2, asid, g, p0, c0, d0, v0, p1, c1, d1, v1);
        @(posedge clk);
        #1;
        model_commit();
        we = 1'b0;
    endtask

    task automatic test_reset();
        model_clear();
        #12;
        s0_vpn2 = '0; s0_asid = '0; s0_odd_page = 1'b0; r_index = 4'd5;
        #1;
        vectors++;
        if (dut_s0() !== 30'h0) begin
            miscompares++;
            $display("FAIL reset_held_s0: got %h want 0", dut_s0());
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        vectors++;
        if (dut_s0() !== 30'h0) begin
            miscompares++;
            $display("FAIL reset_release_s0: got %h want 0", dut_s0());
        end
        vectors++;
        if (dut_r() !== 78'h0) begin
            miscompares++;
            $display("FAIL reset_read_idx5: got %h want 0", dut_r());
        end
    endtask

    task automatic test_write_hit();
        do_write(4'd3, 19'h00010, 8'h2A, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1,
                 20'h54321, 3'd0, 1'b0, 1'b0);
        s0_vpn2 = 19'h00010; s0_asid = 8'h2A; s0_odd_page = 1'b0;
        #1;
        vectors++;
        if (dut_s0() !== {1'b1, 4'd3, 20'h12345, 3'd3, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL hit_even: got %h want %h", dut_s0(),
                     {1'b1, 4'd3, 20'h12345, 3'd3, 1'b1, 1'b1});
        end
        s0_odd_page = 1'b1;
        #1;
        vectors++;
        if (dut_s0() !== {1'b1, 4'd3, 20'h54321, 3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL hit_odd: got %h want %h", dut_s0(),
                     {1'b1, 4'd3, 20'h54321, 3'd0, 1'b0, 1'b0});
        end
        r_index = 4'd3;
        #1;
        vectors++;
        if (dut_r() !== {19'h00010, 8'h2A, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1,
                         20'h54321, 3'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL read_idx3: got %h", dut_r());
        end
    endtask

    task automatic test_asid_global();
        s1_vpn2 = 19'h00010; s1_asid = 8'h2B; s1_odd_page = 1'b0;
        #1;
        vectors++;
        if (s1_found !== 1'b0) begin
            miscompares++;
            $display("FAIL asid_mismatch_found: got %b want 0", s1_found);
        end
        do_write(4'd3, 19'h00010, 8'h2A, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1,
                 20'h54321, 3'd0, 1'b0, 1'b0);
        #1;
        vectors++;
        if ({s1_found, s1_index} !== {1'b1, 4'd3}) begin
            miscompares++;
            $display("FAIL global_hit: got found=%b index=%0d want 1/3", s1_found, s1_index);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        drive_write(4'd7, 19'h7FFFF, 8'h11, 1'b0, 20'hABCDE, 3'd2, 1'b0, 1'b1,
                    20'h0F0F0, 3'd5, 1'b1, 1'b1);
        s0_vpn2 = 19'h7FFFF; s0_asid = 8'h11; s0_odd_page = 1'b0;
        #1;
        vectors++;
        if (s0_found !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_no_bypass: got found=%b want 0", s0_found);
        end
        @(posedge clk);
        #1;
        model_commit();
        we = 1'b0;
        #1;
        vectors++;
        if ({s0_found, s0_index} !== {1'b1, 4'd7}) begin
            miscompares++;
            $display("FAIL next_cycle_hit: got found=%b index=%0d want 1/7", s0_found, s0_index);
        end
    endtask

    task automatic test_dup_priority();
        do_write(4'd9, 19'h00100, 8'h00, 1'b1, 20'h00009, 3'd1, 1'b0, 1'b1,
                 20'h10009, 3'd1, 1'b0, 1'b1);
        do_write(4'd2, 19'h00100, 8'h00, 1'b1, 20'h00002, 3'd1, 1'b0, 1'b1,
                 20'h10002, 3'd1, 1'b0, 1'b1);
        s0_vpn2 = 19'h00100; s0_asid = 8'h55; s0_odd_page = 1'b0;
        #1;
        vectors++;
        if ({s0_found, s0_index, s0_pfn} !== {1'b1, 4'd2, 20'h00002}) begin
            miscompares++;
            $display("FAIL dup_lowest: got index=%0d pfn=%h want 2/00002", s0_index, s0_pfn);
        end
        do_write(4'd2, 19'h00200, 8'h00, 1'b1, 20'h00002, 3'd1, 1'b0, 1'b1,
                 20'h10002, 3'd1, 1'b0, 1'b1);
        #1;
        vectors++;
        if ({s0_found, s0_index, s0_pfn} !== {1'b1, 4'd9, 20'h00009}) begin
            miscompares++;
            $display("FAIL dup_after_overwrite: got index=%0d pfn=%h want 9/00009",
                     s0_index, s0_pfn);
        end
    endtask

    task automatic test_async_reset();
        s0_vpn2 = 19'h00100; s0_asid = 8'h00; s0_odd_page = 1'b0; r_index = 4'd9;
        #1;
        vectors++;
        if (s0_found !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_hit: got %b want 1", s0_found);
        end
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        model_clear();
        vectors++;
        if (s0_found !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_found: got %b want 0", s0_found);
        end
        vectors++;
        if (dut_r() !== 78'h0) begin
            miscompares++;
            $display("FAIL async_reset_read: got %h want 0", dut_r());
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (s0_found !== 1'b0) begin
            miscompares++;
            $display("FAIL after_release_found: got %b want 0", s0_found);
        end
        // A write presented while reset is held must be lost.
        @(negedge clk);
        drive_write(4'd4, 19'h00ABC, 8'h00, 1'b1, 20'hFFFFF, 3'd7, 1'b1, 1'b1,
                    20'hFFFFF, 3'd7, 1'b1, 1'b1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        r_index = 4'd4; s0_vpn2 = 19'h00ABC;
        #1;
        vectors++;
        if ({s0_found, dut_r()} !== 79'h0) begin
            miscompares++;
            $display("FAIL reset_beats_write: found=%b read=%h want 0", s0_found, dut_r());
        end
    endtask

    task automatic test_random();
        logic [29:0] e0, e1;
        logic [77:0] er;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            s0_vpn2 = 19'(19'h10 + $urandom_range(0, 5));
            s0_asid = 8'($urandom_range(0, 2));
            s0_odd_page = 1'($urandom);
            s1_vpn2 = 19'(19'h10 + $urandom_range(0, 5));
            s1_asid = 8'($urandom_range(0, 2));
            s1_odd_page = 1'($urandom);
            r_index = 4'($urandom);
            if ($urandom_range(0, 2) == 0)
                drive_write(4'($urandom), 19'(19'h10 + $urandom_range(0, 5)),
                            8'($urandom_range(0, 2)), $urandom_range(0, 3) == 0,
                            20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                            20'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            #1;
            e0 = model_search(s0_vpn2, s0_asid, s0_odd_page);
            e1 = model_search(s1_vpn2, s1_asid, s1_odd_page);
            er = model_read(r_index);
            vectors++;
            if (dut_s0() !== e0) begin
                miscompares++;
                $display("FAIL rand_s0 n=%0d: got %h want %h", n, dut_s0(), e0);
            end
            vectors++;
            if (dut_s1() !== e1) begin
                miscompares++;
                $display("FAIL rand_s1 n=%0d: got %h want %h", n, dut_s1(), e1);
            end
            vectors++;
            if (dut_r() !== er) begin
                miscompares++;
                $display("FAIL rand_read n=%0d idx=%0d: got %h want %h", n, r_index, dut_r(), er);
            end
            @(posedge clk);
            #1;
            if (we) model_commit();
            we = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_write_hit();
        test_asid_global();
        test_same_cycle();
        test_dup_priority();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
